// File: rtl/tetris_pkg.sv
// Shared playfield types, FSM state encoding and tetromino identifiers.
package tetris_pkg;

  localparam int unsigned DEFAULT_ROWS   = 20;
  localparam int unsigned DEFAULT_COLS   = 10;
  localparam int unsigned DEFAULT_CELL_W = 3;

  typedef logic [DEFAULT_CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam cell_t PIECE_NONE = cell_t'(0);
  localparam cell_t PIECE_I    = cell_t'(1);
  localparam cell_t PIECE_J    = cell_t'(2);
  localparam cell_t PIECE_L    = cell_t'(3);
  localparam cell_t PIECE_O    = cell_t'(4);
  localparam cell_t PIECE_S    = cell_t'(5);
  localparam cell_t PIECE_T    = cell_t'(6);
  localparam cell_t PIECE_Z    = cell_t'(7);

endpackage

// File: rtl/tetromino_rom.sv
// Combinational block-offset table: (piece, rotation, block index) -> offset in the 4x4 box.
module tetromino_rom
  import tetris_pkg::*;
#(
  parameter int unsigned CELL_W = DEFAULT_CELL_W
) (
  input  logic [CELL_W-1:0] piece_type,
  input  logic [1:0]        rotation,
  input  logic [1:0]        index,
  output logic [1:0]        row_off,
  output logic [1:0]        col_off
);

  // Spawn-orientation shapes, four 2-bit coordinates packed with block 0 in the LSBs
  logic [7:0] shape_r;
  logic [7:0] shape_c;
  logic [1:0] span;
  logic       fixed;
  logic [1:0] r0;
  logic [1:0] c0;

  // Base shape lookup; span is the box edge used for clockwise rotation
  always_comb begin
    shape_r = 8'h00;
    shape_c = 8'h00;
    span    = 2'd2;
    fixed   = 1'b0;
    case (piece_type)
      CELL_W'(PIECE_I): begin
        shape_r = {2'd0, 2'd0, 2'd0, 2'd0};
        shape_c = {2'd3, 2'd2, 2'd1, 2'd0};
        span    = 2'd3;
      end
      CELL_W'(PIECE_J): begin
        shape_r = {2'd1, 2'd1, 2'd1, 2'd0};
        shape_c = {2'd2, 2'd1, 2'd0, 2'd0};
      end
      CELL_W'(PIECE_L): begin
        shape_r = {2'd1, 2'd1, 2'd1, 2'd0};
        shape_c = {2'd2, 2'd1, 2'd0, 2'd2};
      end
      CELL_W'(PIECE_O): begin
        shape_r = {2'd1, 2'd1, 2'd0, 2'd0};
        shape_c = {2'd2, 2'd1, 2'd2, 2'd1};
        fixed   = 1'b1;
      end
      CELL_W'(PIECE_S): begin
        shape_r = {2'd1, 2'd1, 2'd0, 2'd0};
        shape_c = {2'd1, 2'd0, 2'd2, 2'd1};
      end
      CELL_W'(PIECE_T): begin
        shape_r = {2'd1, 2'd1, 2'd1, 2'd0};
        shape_c = {2'd2, 2'd1, 2'd0, 2'd1};
      end
      CELL_W'(PIECE_Z): begin
        shape_r = {2'd1, 2'd1, 2'd0, 2'd0};
        shape_c = {2'd2, 2'd1, 2'd1, 2'd0};
      end
      default: begin
        shape_r = 8'h00;
        shape_c = 8'h00;
      end
    endcase
  end

  assign r0 = shape_r[{index, 1'b0} +: 2];
  assign c0 = shape_c[{index, 1'b0} +: 2];

  // Clockwise rotation inside the box: (r,c) -> (c, span-r); O is rotation invariant
  always_comb begin
    row_off = r0;
    col_off = c0;
    if (!fixed) begin
      case (rotation)
        2'd1: begin
          row_off = c0;
          col_off = 2'(span - r0);
        end
        2'd2: begin
          row_off = 2'(span - r0);
          col_off = 2'(span - c0);
        end
        2'd3: begin
          row_off = 2'(span - c0);
          col_off = r0;
        end
        default: begin
          row_off = r0;
          col_off = c0;
        end
      endcase
    end
  end

endmodule

// File: rtl/piece_writer.sv
// Locks a tetromino into the playfield: checks four cells for collision, then writes them.
module piece_writer
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS   = DEFAULT_ROWS,
  parameter int unsigned COLS   = DEFAULT_COLS,
  parameter int unsigned CELL_W = DEFAULT_CELL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock_req,
  input  logic [CELL_W-1:0] piece_type,
  input  logic [1:0]        rotation,
  input  logic [4:0]        base_row,
  input  logic [3:0]        base_col,
  output logic [4:0]        rd_row,
  output logic [3:0]        rd_col,
  input  logic [CELL_W-1:0] rd_data,
  output logic              wr_en,
  output logic [4:0]        wr_row,
  output logic [3:0]        wr_col,
  output logic [CELL_W-1:0] wr_data,
  output logic              busy,
  output logic              lock_ack,
  output logic              collision
);

  state_t            state, state_nx;
  logic [1:0]        idx, idx_nx;
  logic [CELL_W-1:0] p_type;
  logic [1:0]        p_rot;
  logic [4:0]        p_row;
  logic [3:0]        p_col;
  logic              hit, hit_nx;
  logic              cell_oor, oor_nx;
  logic              latch;

  logic [4:0]        rd_row_nx;
  logic [3:0]        rd_col_nx;
  logic              wr_en_nx;
  logic [4:0]        wr_row_nx;
  logic [3:0]        wr_col_nx;
  logic [CELL_W-1:0] wr_data_nx;
  logic              lock_ack_nx;
  logic              collision_nx;

  // The block addressed in the next cycle: from the ports while idle, else from the latched piece
  logic [CELL_W-1:0] look_type;
  logic [1:0]        look_rot;
  logic [4:0]        look_row;
  logic [3:0]        look_col;
  logic [1:0]        look_idx;
  logic [1:0]        row_off;
  logic [1:0]        col_off;
  logic [5:0]        row_sum;
  logic [5:0]        col_sum;
  logic              cell_ok;
  logic              blk_hit;

  tetromino_rom #(
    .CELL_W (CELL_W)
  ) u_rom (
    .piece_type (look_type),
    .rotation   (look_rot),
    .index      (look_idx),
    .row_off    (row_off),
    .col_off    (col_off)
  );

  assign look_type = (state == IDLE) ? piece_type : p_type;
  assign look_rot  = (state == IDLE) ? rotation   : p_rot;
  assign look_row  = (state == IDLE) ? base_row   : p_row;
  assign look_col  = (state == IDLE) ? base_col   : p_col;
  assign look_idx  = (state == IDLE) ? 2'd0 : 2'(idx + 2'd1);

  // 6-bit sums so a box hanging off the bottom/right edge never wraps back in range
  assign row_sum = 6'(look_row) + 6'(row_off);
  assign col_sum = 6'(look_col) + 6'(col_off);
  assign cell_ok = (32'(row_sum) < ROWS) && (32'(col_sum) < COLS);

  assign blk_hit = cell_oor || (rd_data != '0);

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    hit_nx       = hit;
    oor_nx       = 1'b0;
    latch        = 1'b0;
    rd_row_nx    = '0;
    rd_col_nx    = '0;
    wr_en_nx     = 1'b0;
    wr_row_nx    = '0;
    wr_col_nx    = '0;
    wr_data_nx   = '0;
    lock_ack_nx  = 1'b0;
    collision_nx = 1'b0;
    case (state)
      IDLE: begin
        if (lock_req) begin
          latch  = 1'b1;
          hit_nx = 1'b0;
          idx_nx = 2'd0;
          if (piece_type == '0) begin
            state_nx     = DONE;
            lock_ack_nx  = 1'b1;
            collision_nx = 1'b1;
          end else begin
            state_nx  = CHECK;
            oor_nx    = !cell_ok;
            rd_row_nx = cell_ok ? 5'(row_sum) : 5'd0;
            rd_col_nx = cell_ok ? 4'(col_sum) : 4'd0;
          end
        end
      end
      CHECK: begin
        hit_nx = hit || blk_hit;
        idx_nx = look_idx;
        if (idx == 2'd3) begin
          if (hit || blk_hit) begin
            state_nx     = DONE;
            lock_ack_nx  = 1'b1;
            collision_nx = 1'b1;
          end else begin
            state_nx   = WRITE;
            wr_en_nx   = 1'b1;
            wr_row_nx  = 5'(row_sum);
            wr_col_nx  = 4'(col_sum);
            wr_data_nx = p_type;
          end
        end else begin
          oor_nx    = !cell_ok;
          rd_row_nx = cell_ok ? 5'(row_sum) : 5'd0;
          rd_col_nx = cell_ok ? 4'(col_sum) : 4'd0;
        end
      end
      WRITE: begin
        idx_nx = look_idx;
        if (idx == 2'd3) begin
          state_nx    = DONE;
          lock_ack_nx = 1'b1;
        end else begin
          wr_en_nx   = 1'b1;
          wr_row_nx  = 5'(row_sum);
          wr_col_nx  = 4'(col_sum);
          wr_data_nx = p_type;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, latched piece and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      p_type    <= '0;
      p_rot     <= 2'd0;
      p_row     <= 5'd0;
      p_col     <= 4'd0;
      hit       <= 1'b0;
      cell_oor  <= 1'b0;
      rd_row    <= 5'd0;
      rd_col    <= 4'd0;
      wr_en     <= 1'b0;
      wr_row    <= 5'd0;
      wr_col    <= 4'd0;
      wr_data   <= '0;
      busy      <= 1'b0;
      lock_ack  <= 1'b0;
      collision <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      hit       <= hit_nx;
      cell_oor  <= oor_nx;
      if (latch) begin
        p_type <= piece_type;
        p_rot  <= rotation;
        p_row  <= base_row;
        p_col  <= base_col;
      end
      rd_row    <= rd_row_nx;
      rd_col    <= rd_col_nx;
      wr_en     <= wr_en_nx;
      wr_row    <= wr_row_nx;
      wr_col    <= wr_col_nx;
      wr_data   <= wr_data_nx;
      busy      <= (state_nx != IDLE);
      lock_ack  <= lock_ack_nx;
      collision <= collision_nx;
    end
  end

endmodule

// File: tb/tb_piece_writer.sv
// Directed bench for piece_writer with a behavioural playfield memory.
module tb_piece_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lock_req = 1'b0;
  logic [2:0] piece_type = 3'd0;
  logic [1:0] rotation = 2'd0;
  logic [4:0] base_row = 5'd0;
  logic [3:0] base_col = 4'd0;
  logic [4:0] rd_row;
  logic [3:0] rd_col;
  logic [2:0] rd_data;
  logic       wr_en;
  logic [4:0] wr_row;
  logic [3:0] wr_col;
  logic [2:0] wr_data;
  logic       busy;
  logic       lock_ack;
  logic       collision;

  int n_vec = 0;
  int n_err = 0;

  piece_writer dut (
    .clk        (clk),
    .reset      (reset),
    .lock_req   (lock_req),
    .piece_type (piece_type),
    .rotation   (rotation),
    .base_row   (base_row),
    .base_col   (base_col),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .busy       (busy),
    .lock_ack   (lock_ack),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  // Playfield memory: bench-side clear/poke plus DUT writes, all in one process
  logic [2:0] grid [20][10];
  logic       clr_grid = 1'b0;
  logic       poke = 1'b0;
  logic [4:0] poke_r = 5'd0;
  logic [3:0] poke_c = 4'd0;
  logic [2:0] poke_v = 3'd0;

  always @(posedge clk) begin
    if (clr_grid) begin
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 10; c++)
          grid[r][c] <= 3'd0;
    end else if (poke) begin
      grid[poke_r][poke_c] <= poke_v;
    end
    if (wr_en && wr_row < 5'd20 && wr_col < 4'd10)
      grid[wr_row][wr_col] <= wr_data;
  end

  assign rd_data = (rd_row < 5'd20 && rd_col < 4'd10) ? grid[rd_row][rd_col] : 3'd0;

  task automatic check(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic grid_clear();
    @(negedge clk);
    clr_grid = 1'b1;
    @(negedge clk);
    clr_grid = 1'b0;
  endtask

  task automatic grid_poke(input int r, input int c, input int v);
    @(negedge clk);
    poke   = 1'b1;
    poke_r = 5'(r);
    poke_c = 4'(c);
    poke_v = 3'(v);
    @(negedge clk);
    poke = 1'b0;
  endtask

  // Observations from one lock transaction (20-cycle window after the accept edge)
  int first_ack, n_ack, n_wr, busy_cyc, coll_at_ack, zero_viol;
  int wr_r[8];
  int wr_c[8];
  int wr_d[8];

  task automatic run_lock(input int t, input int rot, input int br, input int bc,
                          input int pulse_at);
    first_ack = 0; n_ack = 0; n_wr = 0; busy_cyc = 0; coll_at_ack = -1; zero_viol = 0;
    @(negedge clk);
    piece_type = 3'(t);
    rotation   = 2'(rot);
    base_row   = 5'(br);
    base_col   = 4'(bc);
    lock_req   = 1'b1;
    @(posedge clk);
    #1 lock_req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (lock_ack) begin
        n_ack++;
        if (first_ack == 0) begin
          first_ack   = c;
          coll_at_ack = int'(collision);
        end
      end
      if (wr_en) begin
        if (n_wr < 8) begin
          wr_r[n_wr] = int'(wr_row);
          wr_c[n_wr] = int'(wr_col);
          wr_d[n_wr] = int'(wr_data);
        end
        n_wr++;
      end else if (wr_row != 5'd0 || wr_col != 4'd0 || wr_data != 3'd0) begin
        zero_viol++;
      end
      if (c == pulse_at) lock_req = 1'b1;
      else if (c == pulse_at + 1) lock_req = 1'b0;
    end
  endtask

  int n_rst_wr, n_post_wr, n_post_ack;

  initial begin
    clr_grid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Outputs while reset is held
    check("rst_busy", int'(busy), 0);
    check("rst_lock_ack", int'(lock_ack), 0);
    check("rst_collision", int'(collision), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_addr", int'({rd_row, rd_col}), 0);
    check("rst_wr_fields", int'({wr_row, wr_col, wr_data}), 0);
    @(negedge clk);
    clr_grid = 1'b0;
    reset    = 1'b0;

    // I piece, rotation 0, at (5,3) on an empty field
    run_lock(1, 0, 5, 3, 0);
    check("i0_latency", first_ack, 9);
    check("i0_collision", coll_at_ack, 0);
    check("i0_acks", n_ack, 1);
    check("i0_writes", n_wr, 4);
    check("i0_busy_cycles", busy_cyc, 9);
    check("i0_idle_wr_zero", zero_viol, 0);
    for (int i = 0; i < 4; i++) begin
      check("i0_wr_row", wr_r[i], 5);
      check("i0_wr_col", wr_c[i], 3 + i);
      check("i0_wr_data", wr_d[i], 1);
    end
    check("i0_grid_5_6", int'(grid[5][6]), 1);

    // O piece at (5,3) overlapping an occupied cell (6,4)
    grid_clear();
    grid_poke(6, 4, 2);
    run_lock(4, 0, 5, 3, 0);
    check("o_latency", first_ack, 5);
    check("o_collision", coll_at_ack, 1);
    check("o_writes", n_wr, 0);
    check("o_grid_5_4", int'(grid[5][4]), 0);

    // Vertical I hanging below the bottom row: rows 18..21
    grid_clear();
    run_lock(1, 1, 18, 0, 0);
    check("ivert_latency", first_ack, 5);
    check("ivert_collision", coll_at_ack, 1);
    check("ivert_writes", n_wr, 0);

    // Invalid piece id
    run_lock(0, 0, 0, 0, 0);
    check("inv_latency", first_ack, 1);
    check("inv_collision", coll_at_ack, 1);
    check("inv_busy_cycles", busy_cyc, 1);
    check("inv_writes", n_wr, 0);

    // T piece at (0,0) with a stray lock_req during CHECK
    run_lock(6, 0, 0, 0, 2);
    check("t_acks", n_ack, 1);
    check("t_latency", first_ack, 9);
    check("t_collision", coll_at_ack, 0);
    check("t_writes", n_wr, 4);
    check("t_wr0", wr_r[0] * 16 + wr_c[0], 0 * 16 + 1);
    check("t_wr1", wr_r[1] * 16 + wr_c[1], 1 * 16 + 0);
    check("t_wr2", wr_r[2] * 16 + wr_c[2], 1 * 16 + 1);
    check("t_wr3", wr_r[3] * 16 + wr_c[3], 1 * 16 + 2);
    check("t_wr_data", wr_d[3], 6);

    // Reset right after the second write of an I piece at (10,0)
    grid_clear();
    n_rst_wr = 0;
    @(negedge clk);
    piece_type = 3'd1;
    rotation   = 2'd0;
    base_row   = 5'd10;
    base_col   = 4'd0;
    lock_req   = 1'b1;
    @(posedge clk);
    #1 lock_req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (wr_en) n_rst_wr++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_lock_ack", int'(lock_ack), 0);
    check("rst_mid_wr_en", int'(wr_en), 0);
    repeat (2) begin
      @(negedge clk);
      if (wr_en) n_rst_wr++;
    end
    reset = 1'b0;
    n_post_wr  = 0;
    n_post_ack = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wr_en) n_post_wr++;
      if (lock_ack) n_post_ack++;
    end
    check("rst_mid_writes", n_rst_wr, 2);
    check("rst_post_writes", n_post_wr, 0);
    check("rst_post_acks", n_post_ack, 0);
    check("rst_grid_10_1", int'(grid[10][1]), 1);
    check("rst_grid_10_2", int'(grid[10][2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piece_writer.md
PIECE_WRITER -- requirements
Module: piece_writer

Interface
REQ-001 SHALL have parameter ROWS, default 20: number of playfield rows.
REQ-002 SHALL have parameter COLS, default 10: number of playfield columns.
REQ-003 SHALL have parameter CELL_W, default 3: cell colour code width; 0 means empty.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1: system clock, all state on posedge.
REQ-006 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port lock_req, input, 1: request to lock the piece described by the piece inputs.
REQ-008 SHALL have port piece_type, input, CELL_W: tetromino id 1..7, also the colour written.
REQ-009 SHALL have port rotation, input, 2: rotation 0..3, 90 degrees clockwise steps.
REQ-010 SHALL have port base_row, input, 5: top row of the 4x4 piece box.
REQ-011 SHALL have port base_col, input, 4: left column of the 4x4 piece box.
REQ-012 SHALL have port rd_row, output, 5: grid read row address.
REQ-013 SHALL have port rd_col, output, 4: grid read column address.
REQ-014 SHALL have port rd_data, input, CELL_W: grid cell at rd_row/rd_col, combinational, same cycle.
REQ-015 SHALL have port wr_en, output, 1: write strobe to the grid.
REQ-016 SHALL have port wr_row, output, 5: grid write row.
REQ-017 SHALL have port wr_col, output, 4: grid write column.
REQ-018 SHALL have port wr_data, output, CELL_W: colour to write.
REQ-019 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-020 SHALL have port lock_ack, output, 1: one-cycle completion pulse.
REQ-021 SHALL have port collision, output, 1: valid with lock_ack; 1 means the piece was rejected and nothing was written.

Function
REQ-022 SHALL implement the FSM states IDLE, CHECK, WRITE and DONE.
REQ-023 SHALL accept lock_req only in IDLE, latching piece_type, rotation, base_row and base_col at that edge; lock_req in any other state SHALL be ignored.
REQ-024 SHALL, in CHECK, spend exactly 4 cycles, one per block index 0..3: cell = (base_row+row_off, base_col+col_off), with rd_row/rd_col driven to that cell.
REQ-025 SHALL mark a block as colliding if its cell row >= ROWS, its cell column >= COLS, or rd_data != 0; out-of-range cells SHALL drive rd_row/rd_col to 0 and ignore rd_data.
REQ-026 SHALL compute offset sums at 6 bits so that no wrap-around occurs; base_row=18 with offset 3 is row 21 and SHALL be out of range.
REQ-027 SHALL, after the fourth CHECK cycle, go to WRITE if no block collided, else go to DONE with collision=1.
REQ-028 SHALL, in WRITE, spend exactly 4 cycles with wr_en=1, writing each block in index order with wr_data equal to the latched piece_type.
REQ-029 SHALL, in DONE, assert lock_ack for exactly 1 cycle, hold collision valid in that cycle, and then return to IDLE.
REQ-030 SHALL give a latency from the accept edge to lock_ack of 9 cycles on success and 5 cycles on collision.
REQ-031 SHALL treat piece_type=0 as invalid: no CHECK or WRITE, DONE in the next cycle with collision=1 (latency 1).
REQ-032 SHALL hold wr_en=0 outside WRITE; wr_row, wr_col and wr_data SHALL be 0 when wr_en=0.
REQ-033 SHALL allow lock_req held high through DONE to be re-accepted in the following IDLE cycle; the minimum spacing between accepts is 10 cycles.

Reset
REQ-034 SHALL, on reset, go to IDLE and clear busy, lock_ack, collision, wr_en, all address and data outputs, and the latched piece registers to 0.
REQ-035 SHALL make reset asserted mid-WRITE abort immediately, with no further wr_en pulses; writes already issued are not undone.

Structure
REQ-036 SHALL place ROWS/COLS defaults, the cell_t typedef (CELL_W bits), the state_t enum and the piece-id constants in the shared package tetris_pkg.
REQ-037 SHALL instantiate one sub-module, tetromino_rom: combinational (piece_type, rotation, index) -> (row_off, col_off), 2 bits each, covering all 7x4 shapes.

Verification
REQ-038 SHALL verify: empty grid, I piece (type 1, rot 0), base (5,3) -> 4 writes at (5,3)..(5,6), data 1, lock_ack at cycle 9, collision=0.
REQ-039 SHALL verify: cell (6,4)=2, then O piece (type 4) at base (5,3) covering (5..6, 4..5) -> no wr_en, lock_ack at cycle 5, collision=1.
REQ-040 SHALL verify: I piece rot 1 (vertical) at base_row=18 -> out of range, collision=1, no writes.
REQ-041 SHALL verify: piece_type=0 -> lock_ack at cycle 1, collision=1, busy high for exactly 1 cycle.
REQ-042 SHALL verify: lock_req pulsed during CHECK -> ignored, exactly one lock_ack observed.
REQ-043 SHALL verify: reset asserted after the 2nd write -> exactly 2 wr_en pulses, busy=0 and lock_ack=0 immediately.
